// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode/state encodings and opcode classification for the accumulator CPU
package cpu_pkg;
  localparam int ALU_CLASS_BIT = 3;
  localparam int OPCODE_WIDTH = 4;
  typedef enum logic [OPCODE_WIDTH-1:0] {
    NOP, LDAC, STAC, MVAC, MOVR, JUMP, JMPZ, JPNZ,
    ADD, SUB, INAC, CLAC, AND, OR, XOR, NOT
  } opcode_e;
  typedef enum logic [2:0] {
    START, FETCH, DECODE, OPLO, OPHI, MEMRD, MEMWR, EXEC
  } state_e;
  function automatic logic needs_operand(logic [OPCODE_WIDTH-1:0] op);
    return op == LDAC || op == STAC || op == JUMP || op == JMPZ || op == JPNZ;
  endfunction
  function automatic logic is_alu_op(logic [OPCODE_WIDTH-1:0] op);
    return op >= ADD;
  endfunction
endpackage

// File: rtl/acc_cpu_sequencer.sv
// acc_cpu_sequencer: fetch/decode/execute control for the 8-bit accumulator CPU
module acc_cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  resetN,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  memRead,
  output logic                  memWrite,
  output logic [7:0]            memWdata,
  input  logic [7:0]            memRdata,
  input  logic                  memReady,
  output logic [7:0]            aluAC,
  output logic [7:0]            aluR,
  output logic [2:0]            selectLine,
  input  logic [7:0]            aluResult,
  output logic [7:0]            acOut,
  output logic                  zFlag,
  output logic [ADDR_WIDTH-1:0] pcOut
);
  state_e state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [OPCODE_WIDTH-1:0] ir;
  logic [7:0] ac, r, tr, dr;
  logic z;
  logic [ADDR_WIDTH-1:0] op_addr;
  assign op_addr = ADDR_WIDTH'({dr, tr});
  assign memRead = state == FETCH || state == OPLO || state == OPHI || state == MEMRD;
  assign memWrite = state == MEMWR;
  assign memAddr = (state == MEMRD || state == MEMWR) ? op_addr : pc;
  assign memWdata = ac;
  assign aluAC = ac;
  assign aluR = r;
  assign selectLine = ir[ALU_CLASS_BIT-1:0];
  assign acOut = ac;
  assign zFlag = z;
  assign pcOut = pc;
  // sequencer: request states stall until memReady, EXEC retires register/PC updates
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= START;
      pc <= RESET_PC;
      ir <= '0;
      ac <= '0;
      r <= '0;
      tr <= '0;
      dr <= '0;
      z <= 1'b0;
    end else begin
      case (state)
        START: state <= FETCH;
        FETCH: if (memReady) begin
          ir <= memRdata[OPCODE_WIDTH-1:0];
          pc <= pc + ADDR_WIDTH'(1);
          state <= DECODE;
        end
        DECODE: state <= needs_operand(ir) ? OPLO : EXEC;
        OPLO: if (memReady) begin
          tr <= memRdata;
          pc <= pc + ADDR_WIDTH'(1);
          state <= OPHI;
        end
        OPHI: if (memReady) begin
          dr <= memRdata;
          pc <= pc + ADDR_WIDTH'(1);
          state <= ir == LDAC ? MEMRD : ir == STAC ? MEMWR : EXEC;
        end
        MEMRD: if (memReady) begin
          ac <= memRdata;
          z <= memRdata == 8'h00;
          state <= FETCH;
        end
        MEMWR: if (memReady) state <= FETCH;
        EXEC: begin
          state <= FETCH;
          if (is_alu_op(ir)) begin
            ac <= aluResult;
            z <= aluResult == 8'h00;
          end else begin
            case (ir)
              MVAC: r <= ac;
              MOVR: begin
                ac <= r;
                z <= r == 8'h00;
              end
              JUMP: pc <= op_addr;
              JMPZ: if (z) pc <= op_addr;
              JPNZ: if (!z) pc <= op_addr;
              default: ;
            endcase
          end
        end
        default: state <= START;
      endcase
    end
  end
endmodule

// File: tb/tb_acc_cpu_sequencer.sv
// tb_acc_cpu_sequencer: directed program runs with a memory-transfer scoreboard
module tb_acc_cpu_sequencer;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic memReady = 1'b1;
  logic [15:0] memAddr, pcOut, memAddr_b, pcOut_b;
  logic memRead, memWrite, memRead_b, memWrite_b, zFlag, zFlag_b;
  logic [7:0] memWdata, memRdata, aluAC, aluR, aluResult, acOut;
  logic [7:0] memWdata_b, aluAC_b, aluR_b, aluResult_b, acOut_b;
  logic [7:0] memRdata_b = 8'h00;
  logic memReady_b = 1'b1;
  logic [2:0] selectLine, selectLine_b;
  logic [7:0] mem [0:65535];
  logic [7:0] alu_prog [8] = '{8'h0A, 8'h0A, 8'h03, 8'h0B, 8'h08, 8'h09, 8'h04, 8'h0F};
  logic [7:0] alu_ac [8] = '{8'h01, 8'h02, 8'h02, 8'h00, 8'h02, 8'h00, 8'h02, 8'hFD};
  logic alu_z [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  int compared = 0;
  int mismatched = 0;
  int writes = 0;
  int w0;
  logic [15:0] wr_addr;
  logic [7:0] wr_data;
  typedef struct packed {logic we; logic [15:0] addr; logic [7:0] data;} xfer_t;
  xfer_t exp_q [$];

  always #5 clk = ~clk;

  function automatic logic [7:0] alu(logic [2:0] s, logic [7:0] a, logic [7:0] b);
    case (s)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a + 8'd1;
      3'd3: return 8'h00;
      3'd4: return a & b;
      3'd5: return a | b;
      3'd6: return a ^ b;
      default: return ~a;
    endcase
  endfunction

  assign memRdata = mem[memAddr];
  assign aluResult = alu(selectLine, aluAC, aluR);
  assign aluResult_b = alu(selectLine_b, aluAC_b, aluR_b);

  acc_cpu_sequencer dut (
    .clk(clk), .resetN(resetN), .memAddr(memAddr), .memRead(memRead), .memWrite(memWrite),
    .memWdata(memWdata), .memRdata(memRdata), .memReady(memReady), .aluAC(aluAC), .aluR(aluR),
    .selectLine(selectLine), .aluResult(aluResult), .acOut(acOut), .zFlag(zFlag), .pcOut(pcOut)
  );

  acc_cpu_sequencer #(.ADDR_WIDTH(16), .RESET_PC(16'hFFFF)) dut_b (
    .clk(clk), .resetN(resetN), .memAddr(memAddr_b), .memRead(memRead_b), .memWrite(memWrite_b),
    .memWdata(memWdata_b), .memRdata(memRdata_b), .memReady(memReady_b), .aluAC(aluAC_b), .aluR(aluR_b),
    .selectLine(selectLine_b), .aluResult(aluResult_b), .acOut(acOut_b), .zFlag(zFlag_b), .pcOut(pcOut_b)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // record completed writes
  always @(posedge clk) begin
    if (resetN && memWrite && memReady) begin
      writes <= writes + 1;
      wr_addr <= memAddr;
      wr_data <= memWdata;
    end
  end

  // compare each completed transfer against the next expected one
  always @(negedge clk) begin
    xfer_t o, e;
    if (resetN && (memRead || memWrite) && memReady) begin
      o = '{memWrite, memAddr, memWrite ? memWdata : 8'h00};
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = '{1'b1, 16'hDEAD, 8'hEE};
      chk("xfer", 32'(o), 32'(e));
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(logic [15:0] a);
    exp_q.push_back('{1'b0, a, 8'h00});
  endtask

  task automatic restart();
    resetN = 1'b0;
    memReady = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
  endtask

  task automatic go();
    @(posedge clk);
    #1;
    resetN = 1'b1;
  endtask

  initial begin
    restart();
    mem[0] = 8'h0A;
    rd(16'h0000);
    go();
    chk("rst_read", memRead, 0);
    chk("rst_write", memWrite, 0);
    chk("rst_ac", acOut, 0);
    chk("rst_z", zFlag, 0);
    chk("rst_pc", pcOut, 16'h0000);
    chk("rst_r", aluR, 0);
    chk("rst_pc_b", pcOut_b, 16'hFFFF);
    tick(1);
    chk("inac_fetch_rd", memRead, 1);
    chk("inac_fetch_addr", memAddr, 16'h0000);
    chk("b_fetch_addr", memAddr_b, 16'hFFFF);
    chk("b_fetch_rd", memRead_b, 1);
    tick(2);
    chk("inac_sel", selectLine, 3'b010);
    chk("inac_exec_noreq", memRead, 0);
    tick(1);
    chk("inac_ac", acOut, 8'h01);
    chk("inac_z", zFlag, 0);
    chk("inac_pc", pcOut, 16'h0001);
    chk("b_wrap_addr", memAddr_b, 16'h0000);
    chk("b_wrap_rd", memRead_b, 1);
    chk("b_wrap_pc", pcOut_b, 16'h0000);
    chk("b_ac_z_wr", {acOut_b, zFlag_b, memWrite_b, memWdata_b}, 0);
    restart();
    chk("t1_drained", exp_q.size(), 0);

    mem[0] = 8'h01; mem[1] = 8'h34; mem[2] = 8'h12;
    rd(16'h0000); rd(16'h0001); rd(16'h0002); rd(16'h1234);
    go();
    tick(1);
    chk("ldac_a0", memAddr, 16'h0000);
    tick(2);
    chk("ldac_a1", memAddr, 16'h0001);
    tick(1);
    chk("ldac_a2", memAddr, 16'h0002);
    tick(1);
    chk("ldac_a3", memAddr, 16'h1234);
    chk("ldac_z_before", zFlag, 0);
    tick(1);
    chk("ldac_ac", acOut, 8'h00);
    chk("ldac_z", zFlag, 1);
    chk("ldac_pc", pcOut, 16'h0003);
    chk("ldac_next_fetch", {memRead, memAddr}, {1'b1, 16'h0003});
    restart();
    chk("t2_drained", exp_q.size(), 0);

    mem[0] = 8'h0B; mem[1] = 8'h0A; mem[2] = 8'h02; mem[3] = 8'h34; mem[4] = 8'h12;
    for (int i = 0; i < 5; i++) rd(16'(i));
    exp_q.push_back('{1'b1, 16'h1234, 8'h01});
    w0 = writes;
    go();
    tick(11);
    memReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) memReady = 1'b1;
      chk("stac_hold_wr", {memWrite, memRead}, 2'b10);
      chk("stac_hold_addr", memAddr, 16'h1234);
      chk("stac_hold_data", memWdata, 8'h01);
      tick(1);
    end
    chk("stac_fetch", {memRead, memWrite, memAddr}, {2'b10, 16'h0005});
    chk("stac_writes", writes - w0, 1);
    chk("stac_wr", {wr_addr, wr_data}, {16'h1234, 8'h01});
    restart();
    chk("t3_drained", exp_q.size(), 0);

    mem[0] = 8'h06; mem[1] = 8'h50; mem[2] = 8'h00;
    rd(16'h0000); rd(16'h0001); rd(16'h0002);
    go();
    tick(6);
    chk("jmpz_nt_pc", pcOut, 16'h0003);
    chk("jmpz_nt_addr", memAddr, 16'h0003);
    restart();
    chk("t4a_drained", exp_q.size(), 0);

    mem[0] = 8'h0B; mem[1] = 8'h06; mem[2] = 8'h50; mem[3] = 8'h00;
    for (int i = 0; i < 4; i++) rd(16'(i));
    go();
    tick(9);
    chk("jmpz_t_pc", pcOut, 16'h0050);
    chk("jmpz_t_addr", {memRead, memAddr}, {1'b1, 16'h0050});
    chk("jmpz_t_z", zFlag, 1);
    restart();
    chk("t4b_drained", exp_q.size(), 0);

    mem[0] = 8'h17; mem[1] = 8'h50; mem[2] = 8'h00;
    rd(16'h0000); rd(16'h0001); rd(16'h0002);
    go();
    tick(6);
    chk("jpnz_t_pc", pcOut, 16'h0050);
    restart();
    chk("t4c_drained", exp_q.size(), 0);

    for (int i = 0; i < 8; i++) begin
      mem[i] = alu_prog[i];
      rd(16'(i));
    end
    go();
    tick(1);
    for (int i = 0; i < 8; i++) begin
      tick(3);
      chk($sformatf("alu_ac_%0d", i), acOut, alu_ac[i]);
      chk($sformatf("alu_z_%0d", i), zFlag, alu_z[i]);
    end
    restart();
    chk("t5_drained", exp_q.size(), 0);

    mem[0] = 8'h0A; mem[1] = 8'h03; mem[2] = 8'h01;
    for (int i = 0; i < 4; i++) rd(16'(i));
    go();
    tick(10);
    memReady = 1'b0;
    chk("ophi_wait", {memRead, memAddr}, {1'b1, 16'h0004});
    chk("ophi_r", aluR, 8'h01);
    chk("ophi_ac", acOut, 8'h01);
    #3;
    resetN = 1'b0;
    #1;
    chk("async_rd", memRead, 0);
    chk("async_regs", {acOut, aluR, zFlag, pcOut}, 0);
    memReady = 1'b1;
    chk("t6_drained", exp_q.size(), 0);
    go();
    chk("post_start", {memRead, memWrite, pcOut}, 0);
    tick(1);
    chk("post_fetch", {memRead, memAddr}, {1'b1, 16'h0000});
    chk("post_regs", {acOut, aluR, zFlag}, 0);
    restart();
    chk("final_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/acc_cpu_sequencer.md
Name: acc_cpu_sequencer

Overview:
- Instruction fetch/decode/execute sequencer for the 8-bit accumulator CPU. It is the control-side counterpart of the ALU.
- Holds PC, IR, AC, R, the Z flag and the operand temporaries. Drives the ALU operands and selectLine, and writes the ALU result back into AC.
- Masters the single-port byte memory through a read/write request/ready handshake.
- The ALU sits outside this block; only its inputs and result cross the boundary.

Parameters:
- ADDR_WIDTH, 16: memory address width. Sets the width of PC and of the operand address.
- RESET_PC, 16'h0000: PC value loaded on reset.

Ports:
- clk, input, 1: rising-edge clock.
- resetN, input, 1: reset, asynchronous, active-low.
- memAddr, output, ADDR_WIDTH: memory byte address.
- memRead, output, 1: read request.
- memWrite, output, 1: write request.
- memWdata, output, 8: write data, always equal to AC.
- memRdata, input, 8: read data, valid in the cycle where memReady=1.
- memReady, input, 1: transfer complete this cycle.
- aluAC, output, 8: ALU operand A, always equal to AC.
- aluR, output, 8: ALU operand B, always equal to R.
- selectLine, output, 3: ALU operation, always equal to IR[2:0].
- aluResult, input, 8: ALU result (combinational from aluAC, aluR and selectLine).
- acOut, output, 8: accumulator, for observation.
- zFlag, output, 1: zero flag.
- pcOut, output, ADDR_WIDTH: program counter.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - PC=RESET_PC; IR, AC, R, TR, DR, Z = 0.
  - State = START; memRead = memWrite = 0.
  - Any in-flight memory access is abandoned.
- Opcodes, IR[3:0]; byte[7:4] of the opcode byte is ignored:
  - 0 NOP, 1 LDAC, 2 STAC, 3 MVAC, 4 MOVR, 5 JUMP, 6 JMPZ, 7 JPNZ.
  - 8 ADD, 9 SUB, A INAC, B CLAC, C AND, D OR, E XOR, F NOT. These are the ALU class: IR[3]=1, selectLine=IR[2:0].
- Memory handshake:
  - memRead or memWrite asserts on state entry.
  - memAddr and memWdata are held stable until a cycle with memReady=1; that cycle completes the transfer.
  - memRead and memWrite are never both 1.
  - memReady is ignored when no request is pending.
- Outputs are Moore-decoded from the state and registers.
- States and transitions:
  - START: no request. Always goes to FETCH on the next clk.
  - FETCH: read at PC. On ready: IR<=memRdata[3:0], PC<=PC+1, go to DECODE.
  - DECODE: one cycle, no request.
    - Opcodes 1, 2, 5, 6, 7 go to OPLO.
    - All other opcodes go to EXEC.
  - OPLO: read at PC. On ready: TR<=memRdata, PC<=PC+1, go to OPHI.
  - OPHI: read at PC. On ready: DR<=memRdata, PC<=PC+1.
    - LDAC goes to MEMRD; STAC goes to MEMWR; 5/6/7 go to EXEC.
  - MEMRD: read at {DR,TR}. On ready: AC<=memRdata, Z<=(memRdata==0), go to FETCH.
  - MEMWR: write AC at {DR,TR}. On ready go to FETCH.
  - EXEC: one cycle, then FETCH.
    - NOP: no change.
    - MVAC: R<=AC; Z is unchanged.
    - MOVR: AC<=R, Z<=(R==0).
    - JUMP: PC<={DR,TR}.
    - JMPZ: PC<={DR,TR} if Z=1.
    - JPNZ: PC<={DR,TR} if Z=0.
    - ALU class: AC<=aluResult, Z<=(aluResult==0).
- Operand bytes are always fetched, even for untaken branches. A not-taken branch leaves PC at instruction address+3.
- Cycle counts with memReady tied to 1:
  - NOP, MVAC, MOVR, ALU class: 3 cycles.
  - LDAC, STAC, JUMP, JMPZ, JPNZ: 5 cycles.
  - Each memReady=0 cycle in a request state adds one cycle.
- PC increments wrap modulo 2^ADDR_WIDTH (FFFF+1 = 0000). Operand fetches wrap the same way.
- Z changes only on LDAC, MOVR and the ALU class.

Decomposition:
- Shared package cpu_pkg holds:
  - the 4-bit opcode enum (NOP … NOT);
  - the state enum (START, FETCH, DECODE, OPLO, OPHI, MEMRD, MEMWR, EXEC);
  - the constants ALU_CLASS_BIT=3 and OPCODE_WIDTH=4.
- No sub-module is required. The opcode classification (needsOperand, isAluOp) lives as package functions.

Test Plan:
- Reset, mem[0]=0x0A (INAC), AC=0, ready=1 → after START plus 3 cycles: AC=0x01, Z=0, PC=0x0001, selectLine=3'b010 during EXEC.
- mem[0..2]=01,34,12 and mem[0x1234]=0x00 → memAddr sequence 0000, 0001, 0002, 1234. Then AC=0x00, Z=1, PC=0x0003, 5 cycles total.
- CLAC, INAC, then STAC 0x1234 with memReady=0 for 3 cycles at MEMWR → memWrite, memAddr=0x1234 and memWdata=0x01 held for 4 cycles. Single write; then FETCH at PC=0x0005.
- JMPZ 0x0050 with Z=0 → PC=0x0003. With Z=1 → PC=0x0050, next fetch address 0x0050.
- RESET_PC=16'hFFFF, mem[FFFF]=00 → FETCH at FFFF, then next FETCH at 0x0000.
- resetN pulled low while OPHI waits (memReady=0) → memRead falls immediately. After release: START, then FETCH at RESET_PC, with AC, R and Z all 0.
